// File: rtl/stream_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pingpong_buffer
//  Purpose  : Absorbs a no-backpressure DMA word stream into two SRAM banks
//             used in ping-pong fashion. A bank holding a complete tile is
//             presented to the compute side, read by address, then released.
//  Ports    : clk, rst_n         - clock, async active-low reset
//             clear, tile_len    - sync flush of both banks, tile size latch
//             stream_data/valid  - incoming DMA words (no ready)
//             rd_bank_valid/sel  - presented bank and its FULL status
//             rd_en/addr/data    - bank read port, 1-cycle latency
//             rd_release         - consumer hands presented bank back
//             overflow           - sticky dropped-word flag
//             tiles_written      - completed tile counter (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module stream_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [ADDR_WIDTH:0]   tile_len,
    input  logic [DATA_WIDTH-1:0] stream_data,
    input  logic                  stream_valid,
    output logic                  rd_bank_valid,
    output logic                  rd_bank_sel,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_release,
    output logic                  overflow,
    output logic [15:0]           tiles_written
);

    localparam int                c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth_len = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_one       = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Both banks share one array; the MSB of the address selects the bank.
    logic [DATA_WIDTH-1:0] r_mem [0:2*c_depth-1];

    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_tile_len;
    logic                  r_rd_sel;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic [15:0]           r_tiles;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_wr_accept;
    logic                  w_wr_drop;
    logic                  w_wr_last;
    logic                  w_release;
    logic [1:0]            w_full_nxt;
    logic                  w_rd_sel_nxt;
    logic [ADDR_WIDTH:0]   w_tile_len_in;

    // All decisions use pre-edge bank state, so a word arriving while its
    // target bank is being released in the same cycle is still dropped.
    assign w_wr_accept  = stream_valid & ~clear & ~r_full[r_wr_bank];
    assign w_wr_drop    = stream_valid & ~clear &  r_full[r_wr_bank];
    assign w_wr_last    = w_wr_accept & (r_wr_ptr == (r_tile_len - c_one));
    assign w_release    = rd_release & r_rd_valid & ~clear;
    assign w_rd_sel_nxt = r_rd_sel ^ w_release;

    // A zero length or one larger than a bank means "whole bank".
    assign w_tile_len_in = ((tile_len == '0) || (tile_len > c_depth_len)) ?
                           c_depth_len : tile_len;

    // The completing bank and the released bank are always different: one
    // must be EMPTY to be written, the other FULL to be released.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_tile_len <= c_depth_len;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_tiles    <= 16'd0;
        end else if (clear) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_ptr   <= '0;
            r_tile_len <= w_tile_len_in;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_tiles    <= 16'd0;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
            // Registered view of the presented bank's post-edge state.
            r_rd_valid <= w_full_nxt[w_rd_sel_nxt];
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_last) begin
                r_wr_ptr  <= '0;
                r_wr_bank <= ~r_wr_bank;
                r_tiles   <= r_tiles + 16'd1;
            end else if (w_wr_accept) begin
                r_wr_ptr  <= r_wr_ptr + c_one;
            end
        end
    end

    // SRAM array: no reset on contents.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[{r_wr_bank, r_wr_ptr[ADDR_WIDTH-1:0]}] <= stream_data;
        end
    end

    // Reads are honoured regardless of bank status and use the pre-toggle
    // bank select when issued together with a release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[{r_rd_sel, rd_addr}];
        end
    end

    assign rd_bank_valid = r_rd_valid;
    assign rd_bank_sel   = r_rd_sel;
    assign rd_data       = r_rd_data;
    assign overflow      = r_overflow;
    assign tiles_written = r_tiles;

endmodule
`default_nettype wire

// File: tb/tb_stream_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_pingpong_buffer
//  Purpose  : Directed self-checking bench for stream_pingpong_buffer with a
//             queue-based reference model compared on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_pingpong_buffer;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [AW:0]   tile_len = '0;
    logic [DW-1:0] stream_data = '0;
    logic          stream_valid = 1'b0;
    logic          rd_bank_valid;
    logic          rd_bank_sel;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_release = 1'b0;
    logic          overflow;
    logic [15:0]   tiles_written;

    stream_pingpong_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .tile_len(tile_len),
        .stream_data(stream_data), .stream_valid(stream_valid),
        .rd_bank_valid(rd_bank_valid), .rd_bank_sel(rd_bank_sel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_release(rd_release), .overflow(overflow),
        .tiles_written(tiles_written)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Banks are tracked as a FIFO of completed tiles: the consumer always
    // sees the oldest one; writes alternate bank per completed tile.
    logic [DW-1:0] m_mem   [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            full_q[$];
    int            m_fill, m_tlen, m_completed, m_released;
    bit            m_ovf;
    logic [15:0]   m_tiles;
    logic [DW-1:0] m_rd_data;
    bit            m_rd_known;

    function automatic bit is_full(input int b);
        foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        foreach (m_known[b, a]) m_known[b][a] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                full_q.delete();
                m_fill = 0; m_tlen = DEPTH; m_completed = 0; m_released = 0;
                m_ovf = 1'b0; m_tiles = 16'd0; m_rd_data = '0; m_rd_known = 1'b1;
            end else begin
                if (rd_en) begin
                    m_rd_known = m_known[m_released % 2][rd_addr];
                    m_rd_data  = m_mem[m_released % 2][rd_addr];
                end
                if (clear) begin
                    full_q.delete();
                    m_fill = 0; m_completed = 0; m_released = 0;
                    m_ovf = 1'b0; m_tiles = 16'd0;
                    m_tlen = (tile_len == 0 || int'(tile_len) > DEPTH) ? DEPTH : int'(tile_len);
                end else begin
                    bit rel;
                    int wb;
                    rel = rd_release && is_full(m_released % 2);
                    wb  = m_completed % 2;
                    if (stream_valid) begin
                        if (is_full(wb)) begin
                            m_ovf = 1'b1;
                        end else begin
                            m_mem[wb][m_fill]   = stream_data;
                            m_known[wb][m_fill] = 1'b1;
                            m_fill++;
                            if (m_fill == m_tlen) begin
                                full_q.push_back(wb);
                                m_completed++;
                                m_tiles = m_tiles + 16'd1;
                                m_fill = 0;
                            end
                        end
                    end
                    if (rel) begin
                        void'(full_q.pop_front());
                        m_released++;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd_bank_valid", rd_bank_valid, is_full(m_released % 2));
            chk("m_rd_bank_sel",   rd_bank_sel,   m_released % 2);
            chk("m_overflow",      overflow,      m_ovf);
            chk("m_tiles_written", tiles_written, m_tiles);
            if (m_rd_known) chk("m_rd_data", rd_data, m_rd_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit sv, input logic [DW-1:0] d, input bit re,
                        input logic [AW-1:0] ra, input bit rl);
        stream_valid = sv; stream_data = d; rd_en = re; rd_addr = ra; rd_release = rl;
        @(negedge clk);
        stream_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    endtask

    task automatic do_clear(input logic [AW:0] len);
        clear = 1'b1; tile_len = len;
        @(negedge clk);
        clear = 1'b0;
    endtask

    int sel_seq[$];

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_valid", rd_bank_valid, 0);
        chk("reset_tiles", tiles_written, 0);
        chk("reset_rd_data", rd_data, 0);

        // T1: single tile of 4, readback with 1-cycle latency
        do_clear(5'd4);
        for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0, 0, 0);
        chk("t1_valid", rd_bank_valid, 1);
        chk("t1_sel", rd_bank_sel, 0);
        chk("t1_tiles", tiles_written, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, AW'(i), 0);
            chk("t1_rd_data", rd_data, 32'hA0 + i);
        end

        // T2: both banks fill, 9th word dropped, bank0 intact
        do_clear(5'd4);
        for (int i = 0; i < 8; i++) step(1, 32'hB0 + i, 0, 0, 0);
        chk("t2_tiles", tiles_written, 2);
        chk("t2_ovf_before", overflow, 0);
        step(1, 32'hEE, 0, 0, 0);
        chk("t2_ovf", overflow, 1);
        chk("t2_tiles_after", tiles_written, 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, AW'(i), 0);
            chk("t2_bank0", rd_data, 32'hB0 + i);
        end

        // T4: word + release of wr_bank in same cycle
        step(1, 32'hDD, 0, 0, 1);
        chk("t4_ovf", overflow, 1);
        chk("t4_sel", rd_bank_sel, 1);
        chk("t4_valid", rd_bank_valid, 1);
        for (int i = 0; i < 4; i++) step(1, 32'hC0 + i, 0, 0, 0);
        chk("t4_tiles", tiles_written, 3);
        step(0, 0, 0, 0, 1);
        chk("t4_sel_back", rd_bank_sel, 0);
        step(0, 0, 1, 0, 0);
        chk("t4_bank0_new", rd_data, 32'hC0);

        // T3: continuous ping-pong with prompt release
        do_clear(5'd4);
        for (int c = 0; c < 24; c++) begin
            bit rl;
            rl = rd_bank_valid;
            if (rl) sel_seq.push_back(int'(rd_bank_sel));
            step(c < 16, 32'hD0 + c, 0, 0, rl);
        end
        chk("t3_nrel", sel_seq.size(), 4);
        for (int i = 0; i < 4 && i < sel_seq.size(); i++)
            chk("t3_sel_seq", sel_seq[i], i % 2);
        chk("t3_ovf", overflow, 0);
        chk("t3_tiles", tiles_written, 4);

        // T5: clear discards a partial tile
        do_clear(5'd4);
        step(1, 32'h11, 0, 0, 0);
        step(1, 32'h12, 0, 0, 0);
        do_clear(5'd4);
        for (int i = 0; i < 4; i++) step(1, 32'hE0 + i, 0, 0, 0);
        chk("t5_tiles", tiles_written, 1);
        chk("t5_ovf", overflow, 0);
        chk("t5_sel", rd_bank_sel, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, AW'(i), 0);
            chk("t5_rd_data", rd_data, 32'hE0 + i);
        end

        // T6: tile_len=0 means a full bank, then async reset mid-stream
        do_clear(5'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 32'h100 + i, 0, 0, 0);
        chk("t6_not_yet", tiles_written, 0);
        chk("t6_not_valid", rd_bank_valid, 0);
        step(1, 32'h1FF, 0, 0, 0);
        chk("t6_tiles", tiles_written, 1);
        chk("t6_valid", rd_bank_valid, 1);
        step(0, 0, 1, 4'd15, 0);
        chk("t6_last_word", rd_data, 32'h1FF);
        for (int i = 0; i < 5; i++) step(1, 32'h200 + i, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rd_bank_valid, 0);
        chk("t6_rst_sel", rd_bank_sel, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_tiles", tiles_written, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 32'h300 + i, 0, 0, 0);
        chk("t6_post_rst_len", rd_bank_valid, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
